// File: rtl/main_memory_wait.sv
// rtl/main_memory_wait.sv - wait-state main memory: boot ROM plus zero-on-reset RAM behind a strobe/ACK handshake
module main_memory_wait #(
    parameter int          DATAWIDTH_BUS = 32,
    parameter int unsigned ADDR_BASE     = 32'h0000_0800,
    parameter int          DEPTH_WORDS   = 64,
    parameter int          ROM_WORDS     = 16,
    parameter int          WAIT_STATES   = 2
) (
    input  logic                     MAIN_MEMORY_CLOCK_50,
    input  logic                     MAIN_MEMORY_RESET_InLow,
    input  logic [DATAWIDTH_BUS-1:0] MAIN_MEMORY_data_InBUS,
    input  logic [DATAWIDTH_BUS-1:0] MAIN_MEMORY_ADDRESS_data_InBUS,
    input  logic                     MAIN_MEMORY_RD_data_In,
    input  logic                     MAIN_MEMORY_WR_data_In,
    output logic [DATAWIDTH_BUS-1:0] MAIN_MEMORY_data_OutBUS,
    output logic                     MAIN_MEMORY_ACK,
    output logic                     MAIN_MEMORY_ERR
);
    localparam int DW        = DATAWIDTH_BUS;
    localparam int RAM_WORDS = DEPTH_WORDS - ROM_WORDS;
    localparam int IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [DW-1:0]    BASE_W  = DW'(ADDR_BASE);
    localparam logic [DW-1:0]    LIMIT_W = DW'(4 * DEPTH_WORDS);
    localparam logic [IDX_W-1:0] ROM_IDX = IDX_W'(ROM_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_RELEASE} state_t;

    state_t        state, state_n;
    logic [3:0]    cnt, cnt_n;
    logic          latch_en, do_access;
    logic [DW-1:0] addr_q, data_q;
    logic          rd_q;
    logic [DW-1:0] ram [RAM_WORDS];

    logic             req_rd;
    logic [DW-1:0]    acc_addr, acc_data, acc_off, rd_data;
    logic             acc_rd, in_range, is_rom, acc_err;
    logic [IDX_W-1:0] idx, ram_idx;

    // boot program; words past the program read as zero
    function automatic logic [DW-1:0] rom_word(input logic [IDX_W-1:0] i);
        case (32'(i))
            0:       rom_word = DW'(32'h8210_2000);
            1:       rom_word = DW'(32'h8420_2001);
            2:       rom_word = DW'(32'h8610_2010);
            3:       rom_word = DW'(32'h8810_2000);
            4:       rom_word = DW'(32'h8A00_4002);
            5:       rom_word = DW'(32'h8C21_8003);
            6:       rom_word = DW'(32'h80A1_8000);
            7:       rom_word = DW'(32'h12BF_FFFD);
            8:       rom_word = DW'(32'h0100_0000);
            9:       rom_word = DW'(32'hC820_4001);
            10:      rom_word = DW'(32'h0100_0000);
            11:      rom_word = DW'(32'h0100_0000);
            12:      rom_word = DW'(32'hFFFF_FFFF);
            default: rom_word = '0;
        endcase
    endfunction

    assign req_rd = !MAIN_MEMORY_RD_data_In;

    // with zero wait states the access happens at the sampling edge, so use the live inputs
    always_comb begin
        acc_addr = addr_q;
        acc_data = data_q;
        acc_rd   = rd_q;
        if (state == S_IDLE) begin
            acc_addr = MAIN_MEMORY_ADDRESS_data_InBUS;
            acc_data = MAIN_MEMORY_data_InBUS;
            acc_rd   = req_rd;
        end
        acc_off  = acc_addr - BASE_W;
        in_range = (acc_addr[1:0] == 2'b00) && (acc_addr >= BASE_W) && (acc_off < LIMIT_W);
        idx      = acc_off[IDX_W+1:2];
        is_rom   = idx < ROM_IDX;
        ram_idx  = idx - ROM_IDX;
        acc_err  = !in_range || (!acc_rd && is_rom);
        rd_data  = '0;
        if (in_range) rd_data = is_rom ? rom_word(idx) : ram[ram_idx];
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        latch_en  = 1'b0;
        do_access = 1'b0;
        case (state)
            S_IDLE: begin
                if (!MAIN_MEMORY_RD_data_In || !MAIN_MEMORY_WR_data_In) begin
                    latch_en = 1'b1;
                    cnt_n    = 4'(WAIT_STATES);
                    if (WAIT_STATES == 0) begin
                        state_n   = S_ACK;
                        do_access = 1'b1;
                    end else begin
                        state_n = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_n = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    state_n   = S_ACK;
                    do_access = 1'b1;
                end
            end
            S_ACK:     state_n = S_RELEASE;
            S_RELEASE: if (MAIN_MEMORY_RD_data_In && MAIN_MEMORY_WR_data_In) state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge MAIN_MEMORY_CLOCK_50) begin
        if (!MAIN_MEMORY_RESET_InLow) begin
            state                   <= S_IDLE;
            cnt                     <= '0;
            addr_q                  <= '0;
            data_q                  <= '0;
            rd_q                    <= 1'b0;
            MAIN_MEMORY_ACK         <= 1'b0;
            MAIN_MEMORY_ERR         <= 1'b0;
            MAIN_MEMORY_data_OutBUS <= '0;
            for (int i = 0; i < RAM_WORDS; i++) ram[i] <= '0;
        end else begin
            state           <= state_n;
            cnt             <= cnt_n;
            MAIN_MEMORY_ACK <= do_access;
            MAIN_MEMORY_ERR <= do_access && acc_err;
            if (latch_en) begin
                addr_q <= MAIN_MEMORY_ADDRESS_data_InBUS;
                data_q <= MAIN_MEMORY_data_InBUS;
                rd_q   <= req_rd;
            end
            if (do_access && acc_rd) MAIN_MEMORY_data_OutBUS <= rd_data;
            if (do_access && !acc_rd && !acc_err) ram[ram_idx] <= acc_data;
        end
    end
endmodule

// File: tb/tb_main_memory_wait.sv
// tb/tb_main_memory_wait.sv - scoreboard bench for main_memory_wait with 2 and 0 wait states
module tb_main_memory_wait;
    localparam int WS  = 2;
    localparam int WS0 = 0;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] addr, wdata, addr0, wdata0;
    logic        rd, wr, rd0, wr0;
    logic [31:0] dout, dout0;
    logic        ack, err, ack0, err0;

    always #10 clk = ~clk;

    main_memory_wait #(.WAIT_STATES(WS)) u_dut (
        .MAIN_MEMORY_CLOCK_50          (clk),
        .MAIN_MEMORY_RESET_InLow       (resetn),
        .MAIN_MEMORY_data_InBUS        (wdata),
        .MAIN_MEMORY_ADDRESS_data_InBUS(addr),
        .MAIN_MEMORY_RD_data_In        (rd),
        .MAIN_MEMORY_WR_data_In        (wr),
        .MAIN_MEMORY_data_OutBUS       (dout),
        .MAIN_MEMORY_ACK               (ack),
        .MAIN_MEMORY_ERR               (err)
    );

    main_memory_wait #(.WAIT_STATES(WS0)) u_dut0 (
        .MAIN_MEMORY_CLOCK_50          (clk),
        .MAIN_MEMORY_RESET_InLow       (resetn),
        .MAIN_MEMORY_data_InBUS        (wdata0),
        .MAIN_MEMORY_ADDRESS_data_InBUS(addr0),
        .MAIN_MEMORY_RD_data_In        (rd0),
        .MAIN_MEMORY_WR_data_In        (wr0),
        .MAIN_MEMORY_data_OutBUS       (dout0),
        .MAIN_MEMORY_ACK               (ack0),
        .MAIN_MEMORY_ERR               (err0)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        err;
        int          issue;
    } exp_t;

    exp_t q[$];
    exp_t q0[$];
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got %h required %h", name, act, expv);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (ack === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_ack: got ack=1 with nothing pending, required no ack");
            end else begin
                e = q.pop_front();
                chk("ws2_data", dout, e.data);
                chk("ws2_err", {31'b0, err}, {31'b0, e.err});
                chk("ws2_latency", 32'(cyc - e.issue), 32'(WS + 1));
            end
        end
        if (err === 1'b1 && ack !== 1'b1) begin
            checks++;
            $display("FAIL ws2_err_without_ack: got err=1 ack=0, required err only with ack");
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (ack0 === 1'b1) begin
            if (q0.size() == 0) begin
                checks++;
                $display("FAIL unexpected_ack0: got ack=1 with nothing pending, required no ack");
            end else begin
                e = q0.pop_front();
                chk("ws0_data", dout0, e.data);
                chk("ws0_err", {31'b0, err0}, {31'b0, e.err});
                chk("ws0_latency", 32'(cyc - e.issue), 32'(WS0 + 1));
            end
        end
    end

    // r/w select active strobes; exp_data is data_OutBUS expected at ACK (unchanged for writes)
    task automatic access(input bit d0, input bit r, input bit w, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_data, input bit exp_err,
                          input int hold, input bit wiggle);
        exp_t e;
        bit   got;
        @(negedge clk);
        e.data = exp_data;
        e.err = exp_err;
        e.issue = cyc;
        if (d0) begin
            addr0 = a; wdata0 = d; rd0 = !r; wr0 = !w;
            q0.push_back(e);
        end else begin
            addr = a; wdata = d; rd = !r; wr = !w;
            q.push_back(e);
        end
        if (wiggle) begin
            @(negedge clk);
            addr = 32'h0000_0904; wdata = 32'h0; rd = 1'b1; wr = 1'b1;
        end
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = d0 ? ack0 : ack;
        end
        if (!got) begin
            checks++;
            $display("FAIL ack_timeout: got no ack within 40 cycles for addr %h, required ack", a);
        end
        repeat (hold) @(negedge clk);
        if (d0) begin rd0 = 1'b1; wr0 = 1'b1; end
        else begin rd = 1'b1; wr = 1'b1; end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        resetn = 1'b0;
        rd = 1'b0; wr = 1'b0; addr = 32'h800; wdata = 32'h1234;
        rd0 = 1'b1; wr0 = 1'b1; addr0 = 32'h0; wdata0 = 32'h0;
        repeat (3) @(negedge clk);
        chk("reset_dout", dout, 32'h0);
        chk("reset_ack_err", {30'b0, ack, err}, 32'h0);
        rd = 1'b1; wr = 1'b1;
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        //     d0 r  w  addr          wdata          exp_data       err hold wig
        access(0, 1, 0, 32'h800, 32'h0,         32'h8210_2000, 0, 0, 0);
        access(0, 0, 1, 32'h840, 32'hDEAD_BEEF, 32'h8210_2000, 0, 0, 0);
        access(0, 1, 0, 32'h840, 32'h0,         32'hDEAD_BEEF, 0, 0, 0);
        access(0, 0, 1, 32'h804, 32'h5555_5555, 32'hDEAD_BEEF, 1, 0, 0);
        access(0, 1, 0, 32'h804, 32'h0,         32'h8420_2001, 0, 0, 0);
        access(0, 1, 0, 32'h802, 32'h0,         32'h0,         1, 0, 0);
        access(0, 1, 0, 32'h830, 32'h0,         32'hFFFF_FFFF, 0, 0, 0);
        access(0, 1, 0, 32'h900, 32'h0,         32'h0,         1, 0, 0);
        access(0, 1, 0, 32'h834, 32'h0,         32'h0,         0, 0, 0);
        access(0, 1, 0, 32'h7FC, 32'h0,         32'h0,         1, 0, 0);
        access(0, 1, 0, 32'h8FC, 32'h0,         32'h0,         0, 0, 0);
        access(0, 0, 1, 32'h848, 32'h1111_2222, 32'h0,         0, 0, 0);
        access(0, 1, 1, 32'h848, 32'h9999_9999, 32'h1111_2222, 0, 5, 0);
        access(0, 1, 0, 32'h848, 32'h0,         32'h1111_2222, 0, 0, 0);
        access(0, 1, 0, 32'h800, 32'h0,         32'h8210_2000, 0, 0, 1);

        // reset while a write to 0x844 sits in WAIT: no ACK, no update
        @(negedge clk);
        addr = 32'h844; wdata = 32'hCAFE_F00D; wr = 1'b0;
        @(negedge clk);
        resetn = 1'b0; wr = 1'b1;
        @(negedge clk);
        chk("reset_in_wait_dout", dout, 32'h0);
        resetn = 1'b1;
        repeat (6) @(negedge clk);
        access(0, 1, 0, 32'h844, 32'h0,         32'h0,         0, 0, 0);
        access(0, 1, 0, 32'h840, 32'h0,         32'h0,         0, 0, 0);

        access(1, 1, 0, 32'h804, 32'h0,         32'h8420_2001, 0, 0, 0);
        access(1, 0, 1, 32'h850, 32'h0000_A5A5, 32'h8420_2001, 0, 0, 0);
        access(1, 1, 0, 32'h850, 32'h0,         32'h0000_A5A5, 0, 0, 0);
        access(1, 1, 0, 32'h906, 32'h0,         32'h0,         1, 0, 0);

        repeat (5) @(negedge clk);
        chk("queues_drained", 32'(q.size() + q0.size()), 32'h0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
